alu: RTL and testbench

- 8-bit registered arithmetic/logic unit for the simple accumulator CPU datapath.
- Each clock edge it computes one of eight operations on x_i and y_i, selected by op_i.
- It registers the 8-bit result together with carry and zero flags.
- The status register and accumulator consume r_o and flags_o.

---
 rtl/alu.sv | 95 +++++++++
 tb/tb_alu.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: 8-bit registered arithmetic/logic unit for the accumulator CPU datapath.
// One result and its carry/zero flags are captured on every rising clock edge.
// The result and flags come straight from flops, so they cannot glitch between edges.
module alu (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] x_i,
  input  logic [7:0] y_i,
  input  logic [2:0] op_i,
  output logic [7:0] r_o,
  output logic [1:0] flags_o
);

  // Operation encodings
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Each helper returns {carry, result}.

  // 9-bit sum; the top bit is the unsigned overflow.
  function automatic logic [8:0] op_add(input logic [7:0] a, input logic [7:0] b);
    op_add = {1'b0, a} + {1'b0, b};
  endfunction

  // 9-bit difference; the top bit is the borrow, set when a < b unsigned.
  function automatic logic [8:0] op_sub(input logic [7:0] a, input logic [7:0] b);
    op_sub = {1'b0, a} - {1'b0, b};
  endfunction

  // Left shift by one; the bit shifted out becomes the carry.
  function automatic logic [8:0] op_shl(input logic [7:0] a);
    op_shl = {a[7], a[6:0], 1'b0};
  endfunction

  // Right shift by one, zero fill; the bit shifted out becomes the carry.
  function automatic logic [8:0] op_shr(input logic [7:0] a);
    op_shr = {a[0], 1'b0, a[7:1]};
  endfunction

  logic [8:0] cr_s;      // {carry, result} of the selected operation
  logic [7:0] res_s;
  logic       carry_s;
  logic       zero_s;

  logic [7:0] r_r;
  logic [1:0] flags_r;

  // Select the operation result and carry for the current inputs.
  always_comb begin
    cr_s = 9'h000;
    case (op_i)
      OP_ADD:  cr_s = op_add(x_i, y_i);
      OP_SUB:  cr_s = op_sub(x_i, y_i);
      OP_AND:  cr_s = {1'b0, x_i & y_i};
      OP_OR:   cr_s = {1'b0, x_i | y_i};
      OP_XOR:  cr_s = {1'b0, x_i ^ y_i};
      OP_NOT:  cr_s = {1'b0, ~x_i};
      OP_SHL:  cr_s = op_shl(x_i);
      OP_SHR:  cr_s = op_shr(x_i);
      default: cr_s = 9'h000;
    endcase
  end

  // Split carry/result and derive zero from the 8-bit result for every opcode.
  always_comb begin
    res_s   = cr_s[7:0];
    carry_s = cr_s[8];
    if (cr_s[7:0] == 8'h00) begin
      zero_s = 1'b1;
    end else begin
      zero_s = 1'b0;
    end
  end

  // Result/flag register; reset wins over any operation in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_r     <= 8'h00;
      flags_r <= 2'b00;
    end else begin
      r_r     <= res_s;
      flags_r <= {carry_s, zero_s};
    end
  end

  assign r_o     = r_r;
  assign flags_o = flags_r;

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for alu. Stimulus pushes expected responses computed by
// an arithmetic reference model; a monitor pops and compares after each edge and
// also checks that outputs hold steady while inputs move between edges.
module tb_alu;

  logic       clk_i;
  logic       rst_i;
  logic [7:0] x_i;
  logic [7:0] y_i;
  logic [2:0] op_i;
  logic [7:0] r_o;
  logic [1:0] flags_o;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [7:0] r;
    logic [1:0] f;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  bit   stim_done;

  alu dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .x_i     (x_i),
    .y_i     (y_i),
    .op_i    (op_i),
    .r_o     (r_o),
    .flags_o (flags_o)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t model(input bit rst, input int x, input int y, input int op, input string tag);
    exp_t e;
    int   res;
    int   c;
    res = 0;
    c   = 0;
    case (op)
      0: begin res = (x + y) % 256;       c = (x + y > 255) ? 1 : 0; end
      1: begin res = (x - y + 256) % 256; c = (x < y) ? 1 : 0;       end
      2: res = x & y;
      3: res = x | y;
      4: res = x ^ y;
      5: res = 255 - x;
      6: begin res = (x * 2) % 256; c = (x >= 128) ? 1 : 0; end
      7: begin res = x / 2;         c = x % 2;               end
      default: res = 0;
    endcase
    if (rst) begin
      e.r = 8'h00;
      e.f = 2'b00;
    end else begin
      e.r = res[7:0];
      e.f = {c[0], (res == 0) ? 1'b1 : 1'b0};
    end
    e.tag = tag;
    return e;
  endfunction

  // Drive one cycle at the falling edge; optionally wiggle inputs first.
  task automatic drive(input bit rst, input int x, input int y, input int op,
                       input bit wiggle, input string tag);
    @(negedge clk_i);
    if (wiggle) begin
      x_i  = 8'($urandom);
      y_i  = 8'($urandom);
      op_i = 3'($urandom);
      rst_i = 1'b0;
      #2;
    end
    rst_i = rst;
    x_i   = x[7:0];
    y_i   = y[7:0];
    op_i  = op[2:0];
    sb_q.push_back(model(rst, x, y, op, tag));
  endtask

  // Stimulus: directed boundary cases, then random back-to-back operations.
  initial begin
    stim_done = 1'b0;
    rst_i = 1'b0;
    x_i   = 8'h00;
    y_i   = 8'h00;
    op_i  = 3'b000;
    drive(1'b1, 255, 1, 0, 1'b0, "reset");
    drive(1'b0, 255, 1, 0, 1'b0, "post_reset");
    drive(1'b0, 1, 1, 0, 1'b0, "add_1_1");
    drive(1'b0, 255, 1, 0, 1'b0, "add_wrap");
    drive(1'b0, 7, 3, 1, 1'b0, "sub_7_3");
    drive(1'b0, 2, 2, 1, 1'b0, "sub_eq");
    drive(1'b0, 3, 4, 1, 1'b0, "sub_borrow");
    drive(1'b0, 0, 255, 1, 1'b0, "sub_0_255");
    drive(1'b0, 8'hF0, 8'h0F, 2, 1'b0, "and");
    drive(1'b0, 8'hF0, 8'h0F, 3, 1'b0, "or");
    drive(1'b0, 8'hF0, 8'h0F, 4, 1'b0, "xor");
    drive(1'b0, 8'hFF, 8'h0F, 5, 1'b0, "not");
    drive(1'b0, 8'h81, 8'h00, 6, 1'b0, "shl");
    drive(1'b0, 8'h81, 8'h00, 7, 1'b0, "shr");
    drive(1'b0, 8'h01, 8'h00, 7, 1'b0, "shr_zero");
    drive(1'b1, 8'h12, 8'h34, 1, 1'b1, "reset_mid");
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1), "random");
    end
    stim_done = 1'b1;
  end

  // Monitor: after each edge pop one expectation and compare, then confirm the
  // outputs have not moved just before the next edge despite input changes.
  initial begin
    exp_t e;
    bit   have;
    have = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        have = 1'b1;
        n_cmp++;
        if (r_o !== e.r) begin
          n_bad++;
          $display("FAIL %s r_o: got %02h want %02h", e.tag, r_o, e.r);
        end
        n_cmp++;
        if (flags_o !== e.f) begin
          n_bad++;
          $display("FAIL %s flags_o: got %02b want %02b", e.tag, flags_o, e.f);
        end
      end
      @(negedge clk_i);
      #4;
      if (have) begin
        n_cmp++;
        if (r_o !== e.r || flags_o !== e.f) begin
          n_bad++;
          $display("FAIL %s hold: got %02h/%02b want %02h/%02b", e.tag, r_o, flags_o, e.r, e.f);
        end
      end
    end
  end

  // End of test: bounded wait for stimulus and scoreboard drain, then summary.
  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int t = 0; t < 2000 && !stim_done; t++) @(posedge clk_i);
    repeat (3) @(posedge clk_i);
    #2;
    n_cmp++;
    if (!stim_done || sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: stim_done=%0d pending=%0d want 1/0", stim_done, sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
